uart_tx_arb: RTL



---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_tx_arb_rr_pick.sv | 27 ++
 rtl/uart_tx_arb.sv | 114 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared byte width, default low-timeout and arbiter FSM encoding
package uart_pkg;
    localparam int BYTE_W = 8;
    localparam int DEF_LOW_TIMEOUT = 8;
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_LOW  = 2'd2,
        WAIT_HIGH = 2'd3
    } arb_state_t;
endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// rr_pick: combinational round-robin picker, first eligible index at or after ptr (mod N)
// Ports: elig (eligible mask), ptr (search start) -> win_oh (one-hot), win_idx, any
module rr_pick #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  win_oh,
    output logic [IW-1:0] win_idx,
    output logic          any
);
    logic [IW-1:0] j;
    always_comb begin
        j = '0;
        win_idx = '0;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = IW'((int'(ptr) + k) % N);
            if (!any && elig[j]) begin
                any = 1'b1;
                win_idx = j;
            end
        end
        win_oh = any ? N'(1) << win_idx : '0;
    end
endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter sharing one uart_tx among N_REQ byte requesters
// Ports: clk, rst (async, active-high); req/req_data/req_last from requesters;
//        ack (accept pulse), grant (one-hot owner), busy, err (low-timeout pulse);
//        tx_din/tx_wen to uart_tx, tx_ready from uart_tx.
// Build option: UART_TX_ARB_PKT_LOCK_EN holds the grant on one requester until
//        it delivers a byte flagged req_last.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int LOW_TIMEOUT = DEF_LOW_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [BYTE_W*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        ack,
    output logic [N_REQ-1:0]        grant,
    output logic                    busy,
    output logic                    err,
    output logic [BYTE_W-1:0]       tx_din,
    output logic                    tx_wen,
    input  logic                    tx_ready
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(LOW_TIMEOUT) + 1;

    arb_state_t state, nxt;
    logic [IW-1:0] rr_ptr, ptr_d, win_idx;
    logic [N_REQ-1:0] elig, win_oh, ack_d, grant_d;
    logic [BYTE_W-1:0] din_d;
    logic [CW-1:0] cnt, cnt_d;
    logic any, accept, timeout, keep_grant;

    rr_pick #(.N(N_REQ)) u_pick (
        .elig    (elig),
        .ptr     (rr_ptr),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .any     (any)
    );

    assign accept = state == IDLE && tx_ready && any;
    assign timeout = state == WAIT_LOW && tx_ready && cnt == CW'(LOW_TIMEOUT - 1);

`ifdef UART_TX_ARB_PKT_LOCK_EN
    logic lock_v;
    logic [IW-1:0] lock_idx;
    assign elig = lock_v ? req & (N_REQ'(1) << lock_idx) : req;
    assign keep_grant = lock_v;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_v <= 1'b0;
            lock_idx <= '0;
        end else if (accept) begin
            lock_v <= !req_last[win_idx];
            lock_idx <= win_idx;
        end else if (timeout) begin
            lock_v <= 1'b0;
        end
    end
`else
    logic unused_last;
    assign unused_last = ^req_last;
    assign elig = req;
    assign keep_grant = 1'b0;
`endif

    always_comb begin
        nxt = state;
        case (state)
            IDLE:      nxt = accept ? ISSUE : IDLE;
            ISSUE:     nxt = WAIT_LOW;
            WAIT_LOW:  nxt = !tx_ready ? WAIT_HIGH : timeout ? IDLE : WAIT_LOW;
            WAIT_HIGH: nxt = tx_ready ? IDLE : WAIT_HIGH;
            default:   nxt = IDLE;
        endcase
    end

    // grant is held through the frame and dropped when it ends, unless a packet lock keeps it
    always_comb begin
        ack_d = accept ? win_oh : '0;
        grant_d = accept ? win_oh
                : (timeout || (state == WAIT_HIGH && tx_ready && !keep_grant)) ? '0 : grant;
        din_d = accept ? req_data[win_idx*BYTE_W +: BYTE_W] : tx_din;
        ptr_d = accept ? (win_idx == IW'(N_REQ - 1) ? '0 : win_idx + 1'b1) : rr_ptr;
        cnt_d = state == WAIT_LOW ? cnt + 1'b1 : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rr_ptr <= '0;
            cnt <= '0;
            ack <= '0;
            grant <= '0;
            busy <= 1'b0;
            err <= 1'b0;
            tx_din <= '0;
            tx_wen <= 1'b0;
        end else begin
            state <= nxt;
            rr_ptr <= ptr_d;
            cnt <= cnt_d;
            ack <= ack_d;
            grant <= grant_d;
            busy <= nxt != IDLE;
            err <= timeout;
            tx_din <= din_d;
            tx_wen <= state == ISSUE;
        end
    end
endmodule
